pipe_stage_buf: RTL and testbench

//  Parametrised elastic pipeline-stage buffer; next generation of the held/flushed stage register used between decode and execute.

---
 rtl/core_pkg.sv | 9 +
 rtl/pipe_stage_buf_mem.sv | 31 +++
 rtl/pipe_stage_buf.sv | 72 +++++++
 tb/tb_pipe_stage_buf.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core helpers: width utilities used to size pipeline-stage pointers.
package core_pkg;

  // Pointer width that never collapses to zero bits (a 1-entry buffer still needs a 1-bit pointer)
  function automatic int clog2_min1(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_mem.sv
// Storage array for the elastic stage buffer: one write port, combinational read.
module pipe_stage_buf_mem
  import core_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int DEPTH = 2,
  parameter int PTRW  = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [PTRW-1:0]  i_waddr,
  input  logic [DATAW-1:0] i_wdata,
  input  logic [PTRW-1:0]  i_raddr,
  output logic [DATAW-1:0] o_rdata
);

  logic [DATAW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < DEPTH; i++)
        if (i_waddr == PTRW'(i)) r_mem[i] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic decode->execute stage buffer: valid/ready handshake, DEPTH-entry ring, flush-on-jump.
module pipe_stage_buf
  import core_pkg::*;
#(
  parameter  int DATAW = 32,
  parameter  int DEPTH = 2,
  localparam int PTRW  = clog2_min1(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DATAW-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DATAW-1:0] o_data,
  output logic [CNTW-1:0]  o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [PTRW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            w_push, w_pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // Ready comes only from state, so consumer back-pressure never reaches the producer combinationally
  assign o_ready = !o_full;
  assign o_valid = !o_empty && !i_flush;

  assign w_push = i_valid && o_ready && !i_flush;
  assign w_pop  = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  pipe_stage_buf_mem #(.DATAW(DATAW), .DEPTH(DEPTH), .PTRW(PTRW)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_data)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives DEPTH=1/2/3 buffers with shared stimulus and compares each against a list-based model.
module tb_pipe_stage_buf;

  localparam int NB = 3;
  localparam int DEP [NB] = '{1, 2, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, ivld, irdy;
  logic [31:0] idat;

  logic        vld [NB];
  logic        rdy [NB];
  logic        ful [NB];
  logic        emp [NB];
  logic [31:0] dat [NB];
  logic [3:0]  cnt [NB];
  logic [0:0]  cnt1;
  logic [1:0]  cnt2, cnt3;

  assign cnt[0] = {3'b0, cnt1};
  assign cnt[1] = {2'b0, cnt2};
  assign cnt[2] = {2'b0, cnt3};

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATAW(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(ivld), .o_ready(rdy[0]),
    .i_data(idat), .o_valid(vld[0]), .i_ready(irdy), .o_data(dat[0]),
    .o_count(cnt1), .o_full(ful[0]), .o_empty(emp[0]));
  pipe_stage_buf #(.DATAW(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(ivld), .o_ready(rdy[1]),
    .i_data(idat), .o_valid(vld[1]), .i_ready(irdy), .o_data(dat[1]),
    .o_count(cnt2), .o_full(ful[1]), .o_empty(emp[1]));
  pipe_stage_buf #(.DATAW(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(ivld), .o_ready(rdy[2]),
    .i_data(idat), .o_valid(vld[2]), .i_ready(irdy), .o_data(dat[2]),
    .o_count(cnt3), .o_full(ful[2]), .o_empty(emp[2]));

  // Model: per buffer an ordered list of held payloads, head at index 0
  logic [31:0] mlist [NB][8];
  int          mn    [NB];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) mn[k] = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NB; k++) begin
      bit m_rdy, m_vld, pop, push;
      m_rdy = mn[k] < DEP[k];
      m_vld = (mn[k] > 0) && !flush;
      if (flush) mn[k] = 0;
      else begin
        pop  = m_vld && irdy;
        push = ivld && m_rdy;
        if (pop) begin
          for (int j = 0; j < 7; j++) mlist[k][j] = mlist[k][j+1];
          mn[k]--;
        end
        if (push) begin
          mlist[k][mn[k]] = idat;
          mn[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NB; k++) begin
      logic m_vld;
      m_vld = (mn[k] > 0) && !flush;
      chk($sformatf("d%0d_valid", DEP[k]), 32'(vld[k]), 32'(m_vld));
      chk($sformatf("d%0d_ready", DEP[k]), 32'(rdy[k]), 32'(mn[k] < DEP[k]));
      chk($sformatf("d%0d_count", DEP[k]), 32'(cnt[k]), 32'(mn[k]));
      chk($sformatf("d%0d_full",  DEP[k]), 32'(ful[k]), 32'(mn[k] == DEP[k]));
      chk($sformatf("d%0d_empty", DEP[k]), 32'(emp[k]), 32'(mn[k] == 0));
      if (m_vld) chk($sformatf("d%0d_data", DEP[k]), dat[k], mlist[k][0]);
    end
  endtask

  // Inputs change at negedge, outputs checked 1ns later, model advances on the posedge
  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    ivld = v; idat = d; irdy = r; flush = f;
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("%s_d%0d_valid", tag, DEP[k]), 32'(vld[k]), 32'd0);
      chk($sformatf("%s_d%0d_count", tag, DEP[k]), 32'(cnt[k]), 32'd0);
      chk($sformatf("%s_d%0d_data",  tag, DEP[k]), dat[k], 32'd0);
      chk($sformatf("%s_d%0d_ready", tag, DEP[k]), 32'(rdy[k]), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ivld = 1'b0; irdy = 1'b0; idat = '0;
    model_reset();
    @(negedge clk);
    #1 check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous streaming: full rate for DEPTH>=2, alternating for DEPTH=1
    for (int i = 1; i <= 12; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill under back-pressure; held C must wait until space frees
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent push: 0x33 must never appear
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Random stream with stalls, exercising wrap in every depth
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 39) == 0));

    // Async reset between edges with entries held
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    ivld = 1'b1; idat = 32'h78; irdy = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h5A, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
